// File: rtl/shift_seq_ctrl_64.sv
// ---------------------------------------------------------------------------------------------
// shift_seq_ctrl_64
//
// Multi-cycle shift sequencer for the execute stage. An operand, a shift amount and a shift
// type are accepted over a start/ready handshake. The operand is then shifted by one bit per
// clock until the requested amount is reached. The result is held on data_o until the consumer
// acknowledges it.
//
// Shift types (op_i): 00 SLL, 01 SRL, 10 SRA, 11 ROL.
//
// Ports
//   clk_i    in   1        clock, rising edge
//   rst_i    in   1        asynchronous active-high reset
//   start_i  in   1        request, accepted when start_i && ready_o
//   op_i     in   2        shift type, sampled on acceptance
//   data_i   in   WIDTH    operand, sampled on acceptance
//   shamt_i  in   SHAMT_W  shift amount 0..WIDTH-1, sampled on acceptance
//   flush_i  in   1        synchronous abort, returns to idle on the next edge
//   ack_i    in   1        result consumed (used only while done_o)
//   ready_o  out  1        idle, may accept start_i
//   busy_o   out  1        operation in progress
//   done_o   out  1        data_o holds a valid result
//   data_o   out  WIDTH    shift result, updated only on entry to the done state
// ---------------------------------------------------------------------------------------------

`timescale 1ns / 1ps

module shift_seq_ctrl_64 #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned SHAMT_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               flush_i,
    input  logic               ack_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   data_o
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b10;
    localparam logic [1:0] OpRol = 2'b11;

    localparam logic [SHAMT_W-1:0] CntOne = SHAMT_W'(1);

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0]   work_q,  work_d;
    logic [1:0]         op_q,    op_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [WIDTH-1:0]   work_shifted;

    // One-bit shift of the working register according to the latched op.
    function automatic logic [WIDTH-1:0] shift_one(input logic [1:0]       op,
                                                   input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        case (op)
            OpSll:   r = {w[WIDTH-2:0], 1'b0};
            OpSrl:   r = {1'b0, w[WIDTH-1:1]};
            OpSra:   r = {w[WIDTH-1], w[WIDTH-1:1]};
            OpRol:   r = {w[WIDTH-2:0], w[WIDTH-1]};
            default: r = w;
        endcase
        return r;
    endfunction

    assign work_shifted = shift_one(op_q, work_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        op_d    = op_q;
        data_d  = data_q;

        if (flush_i) begin
            // Flush wins over start and ack; the result register is left untouched.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        work_d  = data_i;
                        op_d    = op_i;
                        cnt_d   = shamt_i;
                        // A zero shift still spends one cycle in the shift state so that
                        // done_o rises one edge after acceptance, like a shift by one.
                        state_d = StShift;
                    end
                end
                StShift: begin
                    if (cnt_q <= CntOne) begin
                        // cnt_q == 0 only for a zero-amount request: pass the operand through.
                        data_d  = (cnt_q == '0) ? work_q : work_shifted;
                        work_d  = data_d;
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        work_d = work_shifted;
                        cnt_d  = cnt_q - CntOne;
                    end
                end
                StDone: begin
                    if (ack_i) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
            op_q    <= OpSll;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    // Status outputs are decoded from the state register only, so they are glitch-free.
    assign ready_o = (state_q == StIdle);
    assign busy_o  = (state_q == StShift);
    assign done_o  = (state_q == StDone);
    assign data_o  = data_q;

endmodule

// File: tb/tb_shift_seq_ctrl_64.sv
`timescale 1ns / 1ps

module tb_shift_seq_ctrl_64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [63:0] data_i;
    logic [5:0]  shamt_i;
    logic        flush_i;
    logic        ack_i;
    logic        ready_o;
    logic        busy_o;
    logic        done_o;
    logic [63:0] data_o;

    int n_total = 0;
    int n_pass  = 0;

    shift_seq_ctrl_64 #(
        .WIDTH   (64),
        .SHAMT_W (6)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .data_i  (data_i),
        .shamt_i (shamt_i),
        .flush_i (flush_i),
        .ack_i   (ack_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] data;
        logic [5:0]  shamt;
        logic [63:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    endtask

    // Behavioural reference: whole-word arithmetic, no per-cycle iteration.
    function automatic logic [63:0] ref_shift(input logic [1:0] op, input logic [63:0] d,
                                              input int s);
        logic [63:0] r;
        case (op)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = $signed(d) >>> s;
            default: r = (s == 0) ? d : ((d << s) | (d >> (64 - s)));
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one operation and wait for done. Returns the observed result and latency.
    task automatic issue(input logic [1:0] op, input logic [63:0] d, input logic [5:0] s,
                         output logic [63:0] res, output int lat, output int busy_cyc);
        int guard;
        guard = 0;
        while (!ready_o && guard < 200) begin
            tick();
            guard++;
        end
        op_i    = op;
        data_i  = d;
        shamt_i = s;
        start_i = 1'b1;
        tick();  // acceptance edge E0
        start_i = 1'b0;
        // Scramble inputs mid-operation; they must be ignored.
        op_i    = 2'($urandom);
        data_i  = {$urandom, $urandom};
        shamt_i = 6'($urandom);
        lat      = 0;
        busy_cyc = 0;
        while (!done_o && lat < 200) begin
            if (busy_o) busy_cyc++;
            tick();
            lat++;
        end
        res = data_o;
    endtask

    task automatic do_ack();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    task automatic run_checked(input string name, input logic [1:0] op, input logic [63:0] d,
                               input logic [5:0] s, input logic [63:0] exp);
        logic [63:0] res;
        int          lat;
        int          bc;
        int          exp_lat;
        exp_lat = (s == 0) ? 1 : int'(s);
        issue(op, d, s, res, lat, bc);
        check({name, " data"}, res, exp);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy cycles"}, 64'(bc), 64'(exp_lat));
        check({name, " ready low in done"}, {63'd0, ready_o}, 64'd0);
        do_ack();
        check({name, " ready after ack"}, {63'd0, ready_o}, 64'd1);
        check({name, " data held after ack"}, data_o, exp);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [63:0] res;
        logic [63:0] prev;
        int          lat;
        int          bc;

        vecs[0] = '{2'b00, 64'h1,                   6'd63, 64'h8000_0000_0000_0000};
        vecs[1] = '{2'b10, 64'h8000_0000_0000_0000, 6'd4,  64'hF800_0000_0000_0000};
        vecs[2] = '{2'b01, 64'h8000_0000_0000_0000, 6'd4,  64'h0800_0000_0000_0000};
        vecs[3] = '{2'b11, 64'h8000_0000_0000_0001, 6'd1,  64'h0000_0000_0000_0003};
        vecs[4] = '{2'b10, 64'h1234,                6'd0,  64'h1234};
        vecs[5] = '{2'b10, 64'h7000_0000_0000_0000, 6'd60, 64'h7};
        vecs[6] = '{2'b11, 64'h8000_0000_0000_0000, 6'd63, 64'h4000_0000_0000_0000};
        vecs[7] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 64'h1};

        rst_i   = 1'b1;
        start_i = 1'b0;
        op_i    = 2'b00;
        data_i  = '0;
        shamt_i = '0;
        flush_i = 1'b0;
        ack_i   = 1'b0;
        #12;
        check("reset ready", {63'd0, ready_o}, 64'd1);
        check("reset busy",  {63'd0, busy_o},  64'd0);
        check("reset done",  {63'd0, done_o},  64'd0);
        check("reset data",  data_o,           64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_checked($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].shamt,
                        vecs[i].exp);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [63:0] d;
            logic [5:0]  s;
            op = 2'($urandom);
            d  = {$urandom, $urandom};
            s  = (i % 8 == 0) ? 6'd0 : ((i % 8 == 1) ? 6'd63 : 6'($urandom));
            run_checked($sformatf("rand%0d op%0d s%0d", i, op, s), op, d, s,
                        ref_shift(op, d, int'(s)));
        end

        // Result held in DONE while ack is withheld; start ignored.
        issue(2'b00, 64'h3, 6'd2, res, lat, bc);
        check("hold initial data", res, 64'hC);
        for (int i = 0; i < 10; i++) begin
            start_i = (i % 2 == 0);
            op_i    = 2'b01;
            data_i  = 64'hDEAD_BEEF;
            shamt_i = 6'd0;
            tick();
            check($sformatf("hold data c%0d", i), data_o, 64'hC);
            check($sformatf("hold done c%0d", i), {63'd0, done_o}, 64'd1);
        end
        start_i = 1'b0;
        do_ack();
        check("hold ready after ack", {63'd0, ready_o}, 64'd1);
        check("hold start not queued", {63'd0, busy_o | done_o}, 64'd0);

        // Flush at cycle 3 of a 20-bit SLL, with start asserted alongside.
        prev    = data_o;
        op_i    = 2'b00;
        data_i  = 64'h1;
        shamt_i = 6'd20;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        flush_i = 1'b1;
        start_i = 1'b1;
        data_i  = 64'hFFFF;
        shamt_i = 6'd1;
        tick();
        flush_i = 1'b0;
        start_i = 1'b0;
        check("flush ready", {63'd0, ready_o}, 64'd1);
        check("flush busy",  {63'd0, busy_o},  64'd0);
        check("flush data",  data_o,           prev);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 30; i++) begin
                tick();
                seen |= done_o | busy_o;
            end
            check("flush no done", {63'd0, seen}, 64'd0);
        end
        check("flush data later", data_o, prev);

        // Flush also clears a pending result in DONE without touching data_o.
        issue(2'b01, 64'hF0, 6'd4, res, lat, bc);
        flush_i = 1'b1;
        ack_i   = 1'b1;
        tick();
        flush_i = 1'b0;
        ack_i   = 1'b0;
        check("flush in done ready", {63'd0, ready_o}, 64'd1);
        check("flush in done data",  data_o,           64'hF);

        // Asynchronous reset in the middle of a shift.
        op_i    = 2'b00;
        data_i  = 64'h5;
        shamt_i = 6'd30;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        check("midreset ready", {63'd0, ready_o}, 64'd1);
        check("midreset busy",  {63'd0, busy_o},  64'd0);
        check("midreset done",  {63'd0, done_o},  64'd0);
        check("midreset data",  data_o,           64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        run_checked("post reset srl", 2'b01, 64'hFF, 6'd8, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
